// File: rtl/data_mem_io.sv
// rtl/data_mem_io.sv - data-side memory stage: word RAM plus memory-mapped I/O page
// Zero-latency reads, stores commit at the clock edge; sticky status drives fault/timer_irq.
module data_mem_io #(
  parameter int          DEPTH_LOG2 = 6,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] led,
  output logic        timer_irq,
  output logic        fault
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [31:0] RAM_SPAN = 32'(4 * DEPTH);

  localparam logic [7:0] OFF_LED  = 8'h00;
  localparam logic [7:0] OFF_CNT  = 8'h04;
  localparam logic [7:0] OFF_STAT = 8'h08;
  localparam logic [7:0] OFF_STC  = 8'h0C;
  localparam logic [7:0] OFF_CMP  = 8'h10;
  localparam logic [7:0] OFF_CTRL = 8'h14;

  logic [31:0] ram_q [DEPTH];

  logic [15:0] led_q, led_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] stc_q, stc_d;
  logic        ctrl_q, ctrl_d;
  logic [2:0]  status_q, status_d;

  logic                  aligned, ram_hit, io_hit;
  logic [7:0]            offset;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  wr_ram, wr_io;
  logic [2:0]            status_set, status_clr;

  // RAM span never exceeds 256 bytes, so one compare also covers addr[31:8]==0.
  always_comb begin
    aligned = (aluout[1:0] == 2'b00);
    ram_hit = (aluout < RAM_SPAN);
    io_hit  = (aluout[31:8] == IO_BASE[31:8]);
    offset  = aluout[7:0];
    ram_idx = aluout[DEPTH_LOG2+1:2];
    wr_ram  = memwrite && aligned && ram_hit;
    wr_io   = memwrite && aligned && io_hit;
  end

  always_comb begin
    readdata = 32'h0;
    if (ram_hit) begin
      readdata = ram_q[ram_idx];
    end else if (io_hit) begin
      case ({offset[7:2], 2'b00})
        OFF_LED:  readdata = {16'h0, led_q};
        OFF_CNT:  readdata = cnt_q;
        OFF_STAT: readdata = {29'h0, status_q};
        OFF_STC:  readdata = stc_q;
        OFF_CMP:  readdata = cmp_q;
        OFF_CTRL: readdata = {31'h0, ctrl_q};
        default:  readdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    led_d  = led_q;
    cnt_d  = cnt_q + 32'd1;
    cmp_d  = cmp_q;
    stc_d  = stc_q;
    ctrl_d = ctrl_q;

    if (wr_ram) stc_d = stc_q + 32'd1;
    if (wr_io) begin
      case (offset)
        OFF_LED:  led_d  = writedata[15:0];
        OFF_CNT:  cnt_d  = writedata;
        OFF_CMP:  cmp_d  = writedata;
        OFF_CTRL: ctrl_d = writedata[0];
        default:  ;
      endcase
    end

    status_set[0] = memwrite && !aligned;
    status_set[1] = memwrite && aligned && !ram_hit && !io_hit;
    status_set[2] = ctrl_q && (cnt_q == cmp_q);
    status_clr    = (wr_io && offset == OFF_STAT) ? writedata[2:0] : 3'b000;
    // Set is applied after clear so a coincident event is never lost.
    status_d      = (status_q & ~status_clr) | status_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= '0;
      cnt_q    <= '0;
      cmp_q    <= '0;
      stc_q    <= '0;
      ctrl_q   <= 1'b0;
      status_q <= '0;
    end else begin
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      stc_q    <= stc_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ram) ram_q[ram_idx] <= writedata;
  end

  assign led       = led_q;
  assign timer_irq = status_q[2] && ctrl_q;
  assign fault     = status_q[0] || status_q[1];

endmodule

// File: tb/tb_data_mem_io.sv
// tb/tb_data_mem_io.sv - directed self-checking bench for data_mem_io
module tb_data_mem_io;

  localparam logic [31:0] IO = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] led;
  logic        timer_irq;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_io #(.DEPTH_LOG2(6), .IO_BASE(IO)) dut (
    .clk       (clk),
    .rst       (rst),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .led       (led),
    .timer_irq (timer_irq),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite  = 1'b1;
    aluout    = a;
    writedata = d;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memwrite = 1'b0;
    aluout   = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b1; memwrite = 1'b0; aluout = '0; writedata = '0;
    tick(); tick();
    rst = 1'b0;

    rd(IO + 32'h00, v); check("rst_led", v, 32'h0);
    rd(IO + 32'h04, v); check("rst_cnt", v, 32'h0);
    rd(IO + 32'h08, v); check("rst_status", v, 32'h0);
    rd(IO + 32'h0C, v); check("rst_stc", v, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);

    wr(32'h10, 32'hDEADBEEF);
    rd(32'h10, v);      check("ram_rd", v, 32'hDEADBEEF);
    rd(32'h13, v);      check("ram_rd_lowbits", v, 32'hDEADBEEF);
    rd(IO + 32'h0C, v); check("stc_1", v, 32'h1);

    wr(32'h12, 32'h0BAD0BAD);
    rd(32'h10, v);      check("misalign_ram", v, 32'hDEADBEEF);
    check("misalign_fault", {31'h0, fault}, 32'h1);
    rd(IO + 32'h08, v); check("misalign_stat", v, 32'h1);
    rd(IO + 32'h0C, v); check("misalign_stc", v, 32'h1);
    wr(IO + 32'h08, 32'h1);
    check("w1c_fault", {31'h0, fault}, 32'h0);

    wr(32'hFC, 32'hCAFEF00D);
    rd(32'hFC, v);      check("last_word", v, 32'hCAFEF00D);
    wr(32'h100, 32'h55555555);
    rd(IO + 32'h08, v); check("oor_stat", v, 32'h2);
    check("oor_fault", {31'h0, fault}, 32'h1);
    rd(32'h100, v);     check("oor_rd", v, 32'h0);
    rd(IO + 32'h0C, v); check("stc_2", v, 32'h2);
    wr(IO + 32'h0C, 32'h1234);
    rd(IO + 32'h0C, v); check("stc_ro", v, 32'h2);
    rd(IO + 32'h18, v); check("io_unmapped", v, 32'h0);
    wr(IO + 32'h08, 32'h3);
    rd(IO + 32'h08, v); check("stat_clr", v, 32'h0);

    wr(IO + 32'h00, 32'h0001ABCD);
    check("led_out", {16'h0, led}, 32'h0000ABCD);
    rd(IO + 32'h00, v); check("led_rd", v, 32'h0000ABCD);

    wr(IO + 32'h10, 32'h105);
    wr(IO + 32'h14, 32'hFFFF_FFFF);
    rd(IO + 32'h14, v); check("ctrl_rd", v, 32'h1);
    rd(IO + 32'h10, v); check("cmp_rd", v, 32'h105);
    wr(IO + 32'h04, 32'h100);
    rd(IO + 32'h04, v); check("cnt_load", v, 32'h100);
    tick();
    rd(IO + 32'h04, v); check("cnt_inc", v, 32'h101);
    repeat (4) tick();
    check("irq_pre", {31'h0, timer_irq}, 32'h0);
    tick();
    check("irq_match", {31'h0, timer_irq}, 32'h1);
    rd(IO + 32'h08, v); check("stat_timer", v, 32'h4);

    wr(IO + 32'h08, 32'h4);
    check("irq_clr", {31'h0, timer_irq}, 32'h0);
    wr(IO + 32'h04, 32'h104);
    tick();
    wr(IO + 32'h08, 32'h4);
    check("set_wins", {31'h0, timer_irq}, 32'h1);
    wr(IO + 32'h08, 32'h4);
    check("irq_clr2", {31'h0, timer_irq}, 32'h0);

    wr(32'h20, 32'h11111111);
    rd(IO + 32'h0C, v); check("stc_pre_rst", v, 32'h3);
    @(negedge clk);
    rst = 1'b1; memwrite = 1'b1; aluout = 32'h20; writedata = 32'h22222222;
    @(posedge clk);
    #1;
    rst = 1'b0; memwrite = 1'b0;
    rd(32'h20, v);      check("rst_store_drop", v, 32'h11111111);
    rd(IO + 32'h0C, v); check("rst_stc2", v, 32'h0);
    check("rst_led2", {16'h0, led}, 32'h0);
    rd(IO + 32'h04, v); check("rst_cnt2", v, 32'h0);
    tick();
    rd(IO + 32'h04, v); check("cnt_restart", v, 32'h1);
    rd(IO + 32'h10, v); check("rst_cmp", v, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
Data-side memory stage that consumes the CPU's memwrite/aluout/writedata and returns readdata within the same cycle, so single-cycle load/store timing holds. It contains a word RAM, and a memory-mapped I/O page with:
- an LED output register
- a free-running cycle counter with compare/interrupt
- a committed-store counter
- a sticky fault/status register

It sits directly downstream of the mips top, in place of a plain data RAM.

Parameters:
DEPTH_LOG2, 6, RAM depth = 2^DEPTH_LOG2 32-bit words (byte span 4*2^DEPTH_LOG2; must be <= 256).
IO_BASE, 32'hFFFF_FF00, base of the 256-byte I/O page; decoded on addr[31:8].

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
memwrite  in  1  store strobe from the CPU.
aluout  in  32  byte address from the CPU.
writedata  in  32  store data.
readdata  out  32  load data; combinational from current address and state.
led  out  16  LED register bits [15:0].
timer_irq  out  1  status bit2 AND ctrl bit0.
fault  out  1  status bit0 OR status bit1.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset clears: led, cycle counter, compare, ctrl, store counter, status. So timer_irq=0, fault=0.
- RAM contents are not reset.
- Address decode:
  - RAM region: addr[31:8]==0 and addr < 4*2^DEPTH_LOG2; word index = addr[DEPTH_LOG2+1:2].
  - IO region: addr[31:8]==IO_BASE[31:8]; offset = addr[7:0].
  - Anything else is out-of-range (OOR).
- Reads: purely combinational, zero latency; addr[1:0] ignored on reads.
  - RAM: return the stored word.
  - IO: return the register at that offset; unmapped IO offsets read 0.
  - OOR: return 0.
- Writes commit at the clk edge when memwrite=1, with these rules:
  - addr[1:0]!=0: write suppressed; status bit0 (misalign) set.
  - OOR with aligned address: write ignored; status bit1 (oor) set.
  - RAM write: store the word; store counter +1 (32-bit, wraps at FFFF_FFFF->0).
  - IO writes do not touch the store counter.
- IO map (offset, access, function):
  - 0x00 R/W: led[15:0]; upper bits read 0, write ignores upper bits.
  - 0x04 R/W: cycle counter. Increments by 1 every cycle while not reset, wrapping at all ones. A write loads writedata and takes priority over the increment, so the next-cycle read returns the written value.
  - 0x08 R/W1C: status. bit0 misalign, bit1 oor, bit2 timer match; other bits read 0. Writing 1 clears the corresponding bit.
  - 0x0C R: store counter; writes ignored, with no fault.
  - 0x10 R/W: compare value.
  - 0x14 R/W: ctrl; bit0 = timer enable, other bits read 0.
- Timer match: when ctrl bit0=1 and the current counter value == compare, status bit2 is set at that edge.
- Status set vs clear in the same cycle: set wins, so the bit reads 1 afterwards.
- Reset asserted mid-operation: a store in that cycle is discarded and all registers are cleared at that edge.
- Boundary: the last RAM word is at 4*2^DEPTH_LOG2-4. The next address up is OOR.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x00000010 and read it back -> readdata=0xDEADBEEF in the same cycle as the read; store counter reads 1 at IO_BASE+0x0C.
- Store to 0x00000012 -> RAM unchanged; fault=1; status reads 0x1. Write 0x1 to status -> fault=0.
- With DEPTH_LOG2=6:
  - Store to 0x000000FC -> accepted.
  - Store to 0x00000100 -> status bit1=1.
  - Load from 0x00000100 -> readdata=0.
- Write 0x0001ABCD to IO_BASE+0x00 -> led=0xABCD; readback=0x0000ABCD.
- Write 0x100 to the counter, compare=0x105, ctrl=1 -> the counter reads 0x101 the cycle after the load. timer_irq rises after the edge where counter==0x105. A W1C to bit2 in the same cycle as another match leaves the bit set.
- Assert rst for one cycle during a RAM store -> the word is not written; store counter=0, led=0, counter restarts from 0.
